// File: rtl/alg_pkg.sv
// Sample and index widths shared by the R-peak detector.
package alg_pkg;

   localparam int DATA_WIDTH  = 11;
   localparam int CTR_WIDTH   = 22;
   localparam int DATA_OFFSET = 1024;

endpackage

// File: rtl/uart_pkg.sv
// UART register map, status layout and serialiser states for the RPD demo.
package uart_pkg;

   localparam logic [2:0] UART_CR_OFFSET    = 3'd0;
   localparam logic [2:0] UART_SR_OFFSET    = 3'd1;
   localparam logic [2:0] UART_DINL_OFFSET  = 3'd2;
   localparam logic [2:0] UART_DINH_OFFSET  = 3'd3;
   localparam logic [2:0] UART_DOUTL_OFFSET = 3'd4;
   localparam logic [2:0] UART_DOUTM_OFFSET = 3'd5;
   localparam logic [2:0] UART_DOUTH_OFFSET = 3'd6;

   typedef struct packed {
      logic [2:0] rsvd;
      logic       overflow;
      logic       tx_fifo_full;
      logic       tx_fifo_empty;
      logic       rx_fifo_full;
      logic       rx_fifo_empty;
   } uart_sr_t;

   typedef enum logic [1:0] {
      PHY_IDLE,
      PHY_START,
      PHY_DATA,
      PHY_STOP
   } phy_state_t;

endpackage

// File: rtl/rpd_uart_phy.sv
// 8N1 UART serialiser/deserialiser, LSB first, mid-bit sampling.
module rpd_uart_phy
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   input  logic       tx_start_i,
   input  logic [7:0] tx_data_i,
   output logic       rx_valid_o,
   output logic [7:0] rx_data_o,
   output logic       tx_o,
   output logic       tx_busy_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   phy_state_t    rx_st_q, rx_st_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_sh_q, rx_sh_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_s1_q, rx_s2_q;

   phy_state_t    tx_st_q, tx_st_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_sh_q, tx_sh_d;
   logic          tx_q, tx_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_st_q    <= PHY_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_valid_q <= 1'b0;
         tx_st_q    <= PHY_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_q       <= 1'b1;
      end else begin
         rx_s1_q    <= rx_i;
         rx_s2_q    <= rx_s1_q;
         rx_st_q    <= rx_st_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_valid_q <= rx_valid_d;
         tx_st_q    <= tx_st_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_q       <= tx_d;
      end
   end

   always_comb begin
      rx_st_d    = rx_st_q;
      rx_cnt_d   = rx_cnt_q + 1'b1;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_valid_d = 1'b0;
      unique case (rx_st_q)
         PHY_IDLE: begin
            rx_cnt_d = '0;
            if (!rx_s2_q) rx_st_d = PHY_START;
         end
         PHY_START: begin
            if (rx_cnt_q == HALF) begin
               rx_cnt_d = '0;
               rx_bit_d = '0;
               rx_st_d  = rx_s2_q ? PHY_IDLE : PHY_DATA;
            end
         end
         PHY_DATA: begin
            if (rx_cnt_q == FULL) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_st_d = PHY_STOP;
            end
         end
         PHY_STOP: begin
            // A low stop bit silently drops the frame.
            if (rx_cnt_q == FULL) begin
               rx_st_d    = PHY_IDLE;
               rx_valid_d = rx_s2_q;
            end
         end
         default: rx_st_d = PHY_IDLE;
      endcase
   end

   always_comb begin
      tx_st_d  = tx_st_q;
      tx_cnt_d = tx_cnt_q + 1'b1;
      tx_bit_d = tx_bit_q;
      tx_sh_d  = tx_sh_q;
      tx_d     = tx_q;
      unique case (tx_st_q)
         PHY_IDLE: begin
            tx_cnt_d = '0;
            tx_d     = 1'b1;
            if (tx_start_i) begin
               tx_sh_d = tx_data_i;
               tx_st_d = PHY_START;
               tx_d    = 1'b0;
            end
         end
         PHY_START: begin
            if (tx_cnt_q == FULL) begin
               tx_cnt_d = '0;
               tx_bit_d = '0;
               tx_st_d  = PHY_DATA;
               tx_d     = tx_sh_q[0];
            end
         end
         PHY_DATA: begin
            if (tx_cnt_q == FULL) begin
               tx_cnt_d = '0;
               tx_sh_d  = {1'b0, tx_sh_q[7:1]};
               tx_bit_d = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) begin
                  tx_st_d = PHY_STOP;
                  tx_d    = 1'b1;
               end else begin
                  tx_d = tx_sh_q[1];
               end
            end
         end
         PHY_STOP: begin
            if (tx_cnt_q == FULL) tx_st_d = PHY_IDLE;
         end
         default: tx_st_d = PHY_IDLE;
      endcase
   end

   assign rx_valid_o = rx_valid_q;
   assign rx_data_o  = rx_sh_q;
   assign tx_o       = tx_q;
   assign tx_busy_o  = (tx_st_q != PHY_IDLE);

endmodule

// File: rtl/rpd_basys3_top.sv
// Basys-3 R-peak detection top: UART register file, FIFOs, detector.
// Optional RPD_SPY_EN mirrors sin/sout/sck_re onto the *_spy pins.
module rpd_basys3_top
   import uart_pkg::*;
   import alg_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic        clk_io,
   input  logic        rst_n,
   input  logic        sin,
   output logic        sout,
   output logic        sin_spy,
   output logic        sout_spy,
   input  logic [15:0] sw,
   input  logic        btnC,
   output logic [15:0] led,
   input  logic        xa4_p,
   input  logic        xa4_n,
   output logic        sck_re,
   output logic        sck_spy
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic       rx_valid, tx_busy, tx_start;
   logic [7:0] rx_data, rd_data;

   logic       btn_s1_q, btn_s2_q, clr;
   logic [7:0] cr_q, dinl_q;
   logic       ovf_q, ovf_d;
   logic       pend_q, pend_d;
   logic [2:0] waddr_q, waddr_d;
   logic       wr_en, rd_en;
   logic [2:0] rd_addr;

   logic [DATA_WIDTH-1:0] s_mem [FIFO_DEPTH];
   logic [AW:0]           s_wp_q, s_rp_q;
   logic                  s_empty, s_full, s_push, s_push_ok, s_pop;
   logic [DATA_WIDTH-1:0] s_head, s_in, prev_q, last_q, thr;

   logic [CTR_WIDTH-1:0]  r_mem [FIFO_DEPTH];
   logic [AW:0]           r_wp_q, r_rp_q;
   logic                  r_empty, r_full, r_push, r_push_ok, r_pop;
   logic [CTR_WIDTH-1:0]  r_head, ctr_q;

   logic        peak, sck_q;
   logic [15:0] led_q;
   uart_sr_t    sr;
   logic        unused_pins;

   rpd_uart_phy #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_phy (
      .clk_i     (clk_io),
      .rst_ni    (rst_n),
      .rx_i      (sin),
      .tx_start_i(tx_start),
      .tx_data_i (rd_data),
      .rx_valid_o(rx_valid),
      .rx_data_o (rx_data),
      .tx_o      (sout),
      .tx_busy_o (tx_busy)
   );

   assign clr     = btn_s2_q;
   assign thr     = sw[DATA_WIDTH-1:0];
   assign rd_addr = rx_data[3:1];

   assign s_empty = (s_wp_q == s_rp_q);
   assign s_full  = (s_wp_q[AW] != s_rp_q[AW]) &&
                    (s_wp_q[AW-1:0] == s_rp_q[AW-1:0]);
   assign r_empty = (r_wp_q == r_rp_q);
   assign r_full  = (r_wp_q[AW] != r_rp_q[AW]) &&
                    (r_wp_q[AW-1:0] == r_rp_q[AW-1:0]);
   assign s_head  = s_mem[s_rp_q[AW-1:0]];
   assign r_head  = r_mem[r_rp_q[AW-1:0]];

   always_comb begin
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      pend_d  = pend_q;
      waddr_d = waddr_q;
      if (rx_valid) begin
         if (pend_q) begin
            wr_en  = 1'b1;
            pend_d = 1'b0;
         end else if (rx_data[7:4] == 4'd0) begin
            if (rx_data[0]) begin
               pend_d  = 1'b1;
               waddr_d = rx_data[3:1];
            end else begin
               rd_en = 1'b1;
            end
         end
      end
   end

   assign sr = '{rsvd: 3'b000, overflow: ovf_q,
                 tx_fifo_full: r_full, tx_fifo_empty: r_empty,
                 rx_fifo_full: s_full, rx_fifo_empty: s_empty};

   always_comb begin
      rd_data = 8'h00;
      case (rd_addr)
         UART_CR_OFFSET:    rd_data = cr_q;
         UART_SR_OFFSET:    rd_data = sr;
         UART_DINL_OFFSET:  rd_data = dinl_q;
         UART_DOUTL_OFFSET: rd_data = r_empty ? 8'h00 : r_head[7:0];
         UART_DOUTM_OFFSET: rd_data = r_empty ? 8'h00 : r_head[15:8];
         UART_DOUTH_OFFSET: rd_data = r_empty ? 8'h00 : {2'b00, r_head[21:16]};
         default:           rd_data = 8'h00;
      endcase
   end

   assign tx_start  = rd_en && !tx_busy;
   assign r_pop     = tx_start && (rd_addr == UART_DOUTH_OFFSET) && !r_empty;
   assign s_in      = {rx_data[2:0], dinl_q};
   assign s_push    = wr_en && (waddr_q == UART_DINH_OFFSET);
   assign s_pop     = cr_q[0] && !s_empty;
   assign s_push_ok = s_push && (!s_full || s_pop);
   assign peak      = (prev_q < thr) && (s_head >= thr);
   assign r_push    = s_pop && peak;
   assign r_push_ok = r_push && (!r_full || r_pop);

   always_comb begin
      ovf_d = ovf_q;
      if (wr_en && (waddr_q == UART_SR_OFFSET) && rx_data[4]) ovf_d = 1'b0;
      if ((s_push && !s_push_ok) || (r_push && !r_push_ok)) ovf_d = 1'b1;
      if (clr) ovf_d = 1'b0;
   end

   always_ff @(posedge clk_io or negedge rst_n) begin
      if (!rst_n) begin
         btn_s1_q <= 1'b0;
         btn_s2_q <= 1'b0;
         cr_q     <= '0;
         dinl_q   <= '0;
         ovf_q    <= 1'b0;
         pend_q   <= 1'b0;
         waddr_q  <= '0;
         s_wp_q   <= '0;
         s_rp_q   <= '0;
         r_wp_q   <= '0;
         r_rp_q   <= '0;
         ctr_q    <= '0;
         prev_q   <= '0;
         last_q   <= '0;
         sck_q    <= 1'b0;
         led_q    <= '0;
      end else begin
         btn_s1_q <= btnC;
         btn_s2_q <= btn_s1_q;
         ovf_q    <= ovf_d;
         pend_q   <= pend_d;
         waddr_q  <= waddr_d;
         sck_q    <= s_pop;
         led_q    <= {ovf_q, r_full, r_empty, s_full, s_empty, last_q};
         if (wr_en && (waddr_q == UART_CR_OFFSET))   cr_q   <= rx_data;
         if (wr_en && (waddr_q == UART_DINL_OFFSET)) dinl_q <= rx_data;
         if (s_pop) last_q <= s_head;
         if (clr) begin
            s_wp_q <= '0;
            s_rp_q <= '0;
            r_wp_q <= '0;
            r_rp_q <= '0;
            ctr_q  <= '0;
            prev_q <= '0;
         end else begin
            if (s_push_ok) s_wp_q <= s_wp_q + 1'b1;
            if (r_push_ok) r_wp_q <= r_wp_q + 1'b1;
            if (r_pop)     r_rp_q <= r_rp_q + 1'b1;
            if (s_pop) begin
               s_rp_q <= s_rp_q + 1'b1;
               prev_q <= s_head;
               if (ctr_q != '1) ctr_q <= ctr_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_io) begin
      if (s_push_ok && !clr) s_mem[s_wp_q[AW-1:0]] <= s_in;
      if (r_push_ok && !clr) r_mem[r_wp_q[AW-1:0]] <= ctr_q;
   end

   assign sck_re = sck_q;
   assign led    = led_q;

`ifdef RPD_SPY_EN
   assign sin_spy  = sin;
   assign sout_spy = sout;
   assign sck_spy  = sck_q;
`else
   assign sin_spy  = 1'b0;
   assign sout_spy = 1'b0;
   assign sck_spy  = 1'b0;
`endif

   assign unused_pins = ^{xa4_p, xa4_n, sw[15:DATA_WIDTH]};

endmodule

// File: tb/tb_rpd_basys3_top.sv
// Scoreboard bench for rpd_basys3_top driving the UART register protocol.
module tb_rpd_basys3_top;
   import uart_pkg::*;

   localparam int CPB = 8;

   logic        clk_io = 1'b0;
   logic        rst_n  = 1'b0;
   logic        sin    = 1'b1;
   logic        btnC   = 1'b0;
   logic [15:0] sw     = 16'h07FF;
   logic        sout, sin_spy, sout_spy, sck_re, sck_spy;
   logic [15:0] led;

   int checks   = 0;
   int failures = 0;
   int sck_cnt  = 0;
   logic [7:0] exp_q[$];

   always #5 clk_io = ~clk_io;

   always @(negedge clk_io) if (sck_re === 1'b1) sck_cnt++;

   rpd_basys3_top #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (16)
   ) dut (
      .clk_io  (clk_io),
      .rst_n   (rst_n),
      .sin     (sin),
      .sout    (sout),
      .sin_spy (sin_spy),
      .sout_spy(sout_spy),
      .sw      (sw),
      .btnC    (btnC),
      .led     (led),
      .xa4_p   (1'b0),
      .xa4_n   (1'b0),
      .sck_re  (sck_re),
      .sck_spy (sck_spy)
   );

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_io);
   endtask

   task automatic send_byte(input logic [7:0] b);
      sin = 1'b0;
      cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         sin = b[i];
         cycles(CPB);
      end
      sin = 1'b1;
      cycles(CPB);
   endtask

   task automatic recv_byte(output logic [7:0] b, output bit ok);
      int n = 0;
      b  = 8'h00;
      ok = 1'b0;
      while (sout !== 1'b0 && n < 30 * CPB) begin
         @(negedge clk_io);
         n++;
      end
      if (sout === 1'b0) begin
         cycles(CPB / 2);
         for (int i = 0; i < 8; i++) begin
            cycles(CPB);
            b[i] = sout;
         end
         cycles(CPB);
         ok = (sout === 1'b1);
      end
   endtask

   task automatic read_reg(input logic [2:0] a, output logic [7:0] v,
                           output bit ok);
      fork
         send_byte({4'h0, a, 1'b0});
         recv_byte(v, ok);
      join
   endtask

   task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
      send_byte({4'h0, a, 1'b1});
      send_byte(d);
   endtask

   task automatic test_reset;
      logic [7:0] got, e;
      bit ok;
      cycles(3);
      checks++;
      if (sout !== 1'b1 || sck_re !== 1'b0) begin
         failures++;
         $display("FAIL reset_io sout=%b sck_re=%b want 1/0", sout, sck_re);
      end
      checks++;
      if (led !== 16'h0000) begin
         failures++;
         $display("FAIL reset_led got=%h want 0000", led);
      end
      rst_n = 1'b1;
      cycles(5);
      exp_q.push_back(8'h05);
      read_reg(UART_SR_OFFSET, got, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || got !== e) begin
         failures++;
         $display("FAIL reset_sr got=%h ok=%0d want %h", got, ok, e);
      end
   endtask

   task automatic test_push;
      logic [7:0] got, e;
      bit ok;
      write_reg(UART_DINL_OFFSET, 8'h34);
      write_reg(UART_DINH_OFFSET, 8'h02);
      cycles(4);
      checks++;
      if (led[10:0] !== 11'h000) begin
         failures++;
         $display("FAIL push_led_idle got=%h want 000", led[10:0]);
      end
      exp_q.push_back(8'h04);
      read_reg(UART_SR_OFFSET, got, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || got !== e) begin
         failures++;
         $display("FAIL push_sr got=%h ok=%0d want %h", got, ok, e);
      end
   endtask

   task automatic test_overflow;
      logic [7:0] got, e;
      bit ok;
      int base;
      for (int i = 0; i < 60; i++) write_reg(UART_DINH_OFFSET, 8'hFF);
      exp_q.push_back(8'h16);
      read_reg(UART_SR_OFFSET, got, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || got !== e) begin
         failures++;
         $display("FAIL ovf_sr_full got=%h ok=%0d want %h", got, ok, e);
      end
      write_reg(UART_SR_OFFSET, 8'h10);
      exp_q.push_back(8'h06);
      read_reg(UART_SR_OFFSET, got, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || got !== e) begin
         failures++;
         $display("FAIL ovf_sr_clear got=%h ok=%0d want %h", got, ok, e);
      end
      base = sck_cnt;
      write_reg(UART_CR_OFFSET, 8'h01);
      cycles(40);
      checks++;
      if (sck_cnt - base !== 16) begin
         failures++;
         $display("FAIL sck_pulses got=%0d want 16", sck_cnt - base);
      end
      checks++;
      if (led[10:0] !== 11'h734) begin
         failures++;
         $display("FAIL led_last got=%h want 734", led[10:0]);
      end
      exp_q.push_back(8'h05);
      read_reg(UART_SR_OFFSET, got, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || got !== e) begin
         failures++;
         $display("FAIL drain_sr got=%h ok=%0d want %h", got, ok, e);
      end
   endtask

   task automatic test_btnc_midframe;
      logic [7:0] got, e;
      bit ok;
      exp_q.push_back(8'h01);
      fork
         read_reg(UART_CR_OFFSET, got, ok);
         begin
            cycles(3 * CPB);
            btnC = 1'b1;
            cycles(4);
            btnC = 1'b0;
         end
      join
      e = exp_q.pop_front();
      checks++;
      if (!ok || got !== e) begin
         failures++;
         $display("FAIL btnc_cr got=%h ok=%0d want %h", got, ok, e);
      end
   endtask

   task automatic test_peaks;
      logic [7:0] got, e;
      bit ok;
      logic [10:0] smp [4] = '{11'd0, 11'd1024, 11'd500, 11'd1500};
      logic [2:0]  ra  [8] = '{UART_SR_OFFSET, UART_DOUTL_OFFSET,
                               UART_DOUTM_OFFSET, UART_DOUTH_OFFSET,
                               UART_DOUTL_OFFSET, UART_DOUTM_OFFSET,
                               UART_DOUTH_OFFSET, UART_SR_OFFSET};
      logic [7:0]  rv  [8] = '{8'h01, 8'h01, 8'h00, 8'h00,
                               8'h03, 8'h00, 8'h00, 8'h05};
      sw = 16'd1000;
      cycles(4);
      for (int i = 0; i < 4; i++) begin
         write_reg(UART_DINL_OFFSET, smp[i][7:0]);
         write_reg(UART_DINH_OFFSET, {5'b0, smp[i][10:8]});
      end
      cycles(10);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(rv[i]);
         read_reg(ra[i], got, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || got !== e) begin
            failures++;
            $display("FAIL peak_rd%0d addr=%0d got=%h ok=%0d want %h",
                     i, ra[i], got, ok, e);
         end
      end
   endtask

   task automatic test_empty_pop;
      logic [7:0] got, e;
      bit ok;
      logic [2:0] ra [3] = '{UART_DOUTH_OFFSET, UART_SR_OFFSET,
                             UART_DOUTL_OFFSET};
      logic [7:0] rv [3] = '{8'h00, 8'h05, 8'h00};
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(rv[i]);
         read_reg(ra[i], got, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || got !== e) begin
            failures++;
            $display("FAIL empty_rd%0d got=%h ok=%0d want %h", i, got, ok, e);
         end
      end
   endtask

   task automatic test_spy;
      logic [2:0] want;
`ifdef RPD_SPY_EN
      want = {sin, sout, sck_re};
`else
      want = 3'b000;
`endif
      checks++;
      if ({sin_spy, sout_spy, sck_spy} !== want) begin
         failures++;
         $display("FAIL spy got=%b want %b", {sin_spy, sout_spy, sck_spy}, want);
      end
   endtask

   task automatic test_reset_midresp;
      logic [7:0] got, e;
      bit ok;
      logic [2:0] ra [3] = '{UART_CR_OFFSET, UART_SR_OFFSET,
                             UART_DINL_OFFSET};
      logic [7:0] rv [3] = '{8'h00, 8'h05, 8'h00};
      send_byte({4'h0, UART_CR_OFFSET, 1'b0});
      cycles(2 * CPB);
      rst_n = 1'b0;
      #1;
      checks++;
      if (sout !== 1'b1) begin
         failures++;
         $display("FAIL midresp_sout got=%b want 1", sout);
      end
      checks++;
      if (led !== 16'h0000) begin
         failures++;
         $display("FAIL midresp_led got=%h want 0000", led);
      end
      cycles(3);
      rst_n = 1'b1;
      cycles(5);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(rv[i]);
         read_reg(ra[i], got, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || got !== e) begin
            failures++;
            $display("FAIL postrst_rd%0d got=%h ok=%0d want %h", i, got, ok, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_push();
      test_overflow();
      test_btnc_midframe();
      test_peaks();
      test_empty_pop();
      test_spy();
      test_reset_midresp();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
